// File: rtl/regfile_mp_sb.sv
// Multi-port register file: NUM_RD read ports, two write ports (port 1 has priority),
// optional write-to-read bypass, selectable read latency and a per-register busy scoreboard.
module regfile_mp_sb_rdport #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 16,
   parameter int AW       = 4,
   parameter int READ_LAT = 0,
   parameter int BYPASS   = 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [AW-1:0]                addr,
   input  logic                         addr_ok,
   input  logic [DEPTH-1:0][WIDTH-1:0]  mem,
   input  logic [DEPTH-1:0]             busy,
   input  logic                         w0_ok,
   input  logic [AW-1:0]                wa0,
   input  logic [WIDTH-1:0]             wd0,
   input  logic                         w1_ok,
   input  logic [AW-1:0]                wa1,
   input  logic [WIDTH-1:0]             wd1,
   input  logic                         rsv_ok,
   input  logic [AW-1:0]                rsv_addr,
   output logic [WIDTH-1:0]             rd_data,
   output logic                         rd_busy
);
   logic             hit0, hit1;
   logic [WIDTH-1:0] d_nxt, d_q;
   logic             b_nxt, b_q;

   // The forwarded value equals the post-edge content, so the registered path reuses it.
   always_comb begin
      hit0  = w0_ok && (wa0 == addr);
      hit1  = w1_ok && (wa1 == addr);
      d_nxt = '0;
      b_nxt = 1'b0;
      if (addr_ok) begin
         d_nxt = mem[addr];
         b_nxt = busy[addr];
         if (BYPASS != 0) begin
            if (hit1)      d_nxt = wd1;
            else if (hit0) d_nxt = wd0;
            if ((hit0 || hit1) && !(rsv_ok && (rsv_addr == addr))) b_nxt = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_q <= '0;
         b_q <= 1'b0;
      end else begin
         d_q <= d_nxt;
         b_q <= b_nxt;
      end
   end

   assign rd_data = (READ_LAT != 0) ? d_q : d_nxt;
   assign rd_busy = (READ_LAT != 0) ? b_q : b_nxt;
endmodule

module regfile_mp_sb #(
   parameter int  WIDTH     = 16,
   parameter int  DEPTH     = 16,
   parameter int  NUM_RD    = 2,
   parameter int  READ_LAT  = 0,
   parameter int  BYPASS    = 1,
   parameter int  ZERO_REG0 = 0,
   localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_RD*AW-1:0]    rd_addr,
   output logic [NUM_RD*WIDTH-1:0] rd_data,
   output logic [NUM_RD-1:0]       rd_busy,
   input  logic                    we0,
   input  logic [AW-1:0]           wa0,
   input  logic [WIDTH-1:0]        wd0,
   input  logic                    we1,
   input  logic [AW-1:0]           wa1,
   input  logic [WIDTH-1:0]        wd1,
   input  logic                    rsv_en,
   input  logic [AW-1:0]           rsv_addr,
   output logic                    rsv_conflict,
   output logic [DEPTH-1:0]        busy
);
   logic [DEPTH-1:0][WIDTH-1:0] mem;
   logic [DEPTH-1:0]            busy_q;
   logic                        w0_ok, w1_ok, rsv_ok;

   function automatic logic addr_ok(input logic [AW-1:0] a);
      return (32'(a) < DEPTH) && !((ZERO_REG0 != 0) && (a == '0));
   endfunction

   assign w0_ok  = we0 && addr_ok(wa0);
   assign w1_ok  = we1 && addr_ok(wa1);
   assign rsv_ok = rsv_en && addr_ok(rsv_addr);

   // Port 1 is applied last so it wins an address collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem <= '0;
      end else begin
         if (w0_ok) mem[wa0] <= wd0;
         if (w1_ok) mem[wa1] <= wd1;
      end
   end

   // Reserve is applied after the write clears: a new producer keeps the register busy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         if (w0_ok)  busy_q[wa0]      <= 1'b0;
         if (w1_ok)  busy_q[wa1]      <= 1'b0;
         if (rsv_ok) busy_q[rsv_addr] <= 1'b1;
      end
   end

   assign busy         = busy_q;
   assign rsv_conflict = rsv_ok && busy_q[rsv_addr];

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      logic [AW-1:0] ra;
      logic          ra_ok;
      assign ra    = rd_addr[i*AW +: AW];
      assign ra_ok = addr_ok(ra);

      regfile_mp_sb_rdport #(
         .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .READ_LAT(READ_LAT), .BYPASS(BYPASS)
      ) u_port (
         .clk      (clk),
         .rst_n    (rst_n),
         .addr     (ra),
         .addr_ok  (ra_ok),
         .mem      (mem),
         .busy     (busy_q),
         .w0_ok    (w0_ok),
         .wa0      (wa0),
         .wd0      (wd0),
         .w1_ok    (w1_ok),
         .wa1      (wa1),
         .wd1      (wd1),
         .rsv_ok   (rsv_ok),
         .rsv_addr (rsv_addr),
         .rd_data  (rd_data[i*WIDTH +: WIDTH]),
         .rd_busy  (rd_busy[i])
      );
   end
endmodule
